// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and frame constants, also used by the receive side.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   FRAME_BITS_NOPAR = 10;
  localparam int   FRAME_BITS_PAR   = 11;
  localparam logic LINE_IDLE        = 1'b1;
  localparam logic START_BIT        = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_bitcnt.sv
// Transmit-side sample counter and frame bit counter; mirrors the receive bit counter.
// bit_end fires on the enable tick that closes the current bit.
module uart_tx_bitcnt
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = FRAME_BITS_NOPAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic       run,
  output logic       bit_end,
  output logic [3:0] bit_cnt
);

  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST    = 4'(FRAME_BITS - 1);

  logic [3:0] sample_q, sample_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;

  assign bit_end = run && enable && (sample_q == SAMPLE_LAST);
  assign bit_cnt = bit_cnt_q;

  // The bit index wraps to 0 at the stop-bit end so an idle line reads as bit 0.
  always_comb begin
    sample_d  = sample_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      sample_d  = '0;
      bit_cnt_d = '0;
    end else if (bit_end) begin
      sample_d  = '0;
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (run && enable) begin
      sample_d = sample_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      sample_q  <= sample_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (11-bit frame instead of 10).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [3:0]        bit_cnt
);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif
  localparam logic [3:0] DATA_LAST = 4'(DATA_W);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  uart_tx_bitcnt #(
    .OVERSAMPLE (OVERSAMPLE),
    .FRAME_BITS (FRAME_BITS)
  ) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clear   (accept),
    .run     (busy_q),
    .bit_end (bit_end),
    .bit_cnt (bit_cnt)
  );

  // Every transition except acceptance waits for bit_end, so enable=0 freezes the frame.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          shift_d = tx_data;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = LINE_IDLE;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: idle line, frame contents, bit timing with a slow/paused
// enable, back-to-back frames, mid-frame reset and (with UART_TX_PARITY_EN) the parity bit.
module tb_uart_tx;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * OS;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       txStart;
  logic [7:0] txData;
  logic       tx;
  logic       busy;
  logic       txDone;
  logic [3:0] bitCnt;

  int compared   = 0;
  int mismatched = 0;
  int enDiv      = 1;
  int phase      = 0;
  logic hold     = 1'b0;

  uart_tx #(
    .DATA_W     (8),
    .OVERSAMPLE (OS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .tx_start (txStart),
    .tx_data  (txData),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (txDone),
    .bit_cnt  (bitCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick generator: one enable per enDiv clocks; while hold is set the tick is
  // suppressed and the phase frozen, so a hold of N clocks delays every later tick by N.
  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold) begin
        enable = 1'b0;
      end else begin
        enable = (phase == 0);
        phase  = (phase + 1) % enDiv;
      end
    end
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic start, input logic [7:0] data);
    txStart = start;
    txData  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected line level for frame bit idx of byte d
  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic waitBitCnt(input logic [3:0] target, input int maxc, output int n);
    n = 0;
    while (bitCnt !== target && n < maxc) begin
      tick();
      n++;
    end
  endtask

  // Called one sample after the accept edge with enable=1 every clock; returns at the
  // sample just after the stop-bit end.
  task automatic checkFrame(input string tag, input logic [7:0] data);
    int busyCnt = 0;
    int doneCnt = 0;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      if (busy === 1'b1) busyCnt++;
      if (txDone === 1'b1) doneCnt++;
      if (c % OS == OS / 2)
        checkOutput($sformatf("%s_bit%0d", tag, c / OS), tx, frameBit(data, c / OS));
      if (c == (NBITS - 1) * OS + OS / 2)
        checkOutput($sformatf("%s_bitcnt_last", tag), bitCnt, NBITS - 1);
      tick();
    end
    checkOutput($sformatf("%s_busy_clks", tag), busyCnt, FRAME_CLKS);
    checkOutput($sformatf("%s_done_early", tag), doneCnt, 0);
    checkOutput($sformatf("%s_done", tag), txDone, 1);
    checkOutput($sformatf("%s_busy_end", tag), busy, 0);
    checkOutput($sformatf("%s_bitcnt_end", tag), bitCnt, 0);
  endtask

  initial begin
    int bad;
    int n;
    int extra;

    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);
    repeat (3) tick();
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", txDone, 0);
    checkOutput("rst_bitcnt", bitCnt, 0);

    // 1) idle line with enable running and no request
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || txDone !== 1'b0) bad++;
    end
    checkOutput("t1_idle_bad", bad, 0);

    // 2) single frame 0xA5; tx_data changes right after acceptance
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h5A);
    checkOutput("t2_accept_tx", tx, 0);
    checkOutput("t2_accept_busy", busy, 1);
    checkFrame("t2", 8'hA5);
    tick();
    checkOutput("t2_done_clear", txDone, 0);
    repeat (5) tick();

    // 3) enable 1-in-4, byte 0x00, bit 3 paused for 50 clocks
    enDiv = 4;
    repeat (8) tick();
    applyStimulus(1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 8'hFF);
    checkOutput("t3_accept_tx", tx, 0);
    waitBitCnt(4'd1, 100, n);
    checkOutput("t3_start_len_ok", (n >= 61 && n <= 64), 1);
    for (int b = 1; b <= 8; b++) begin
      extra = 0;
      if (b == 3) begin
        repeat (20) tick();
        hold = 1'b1;
        repeat (50) tick();
        hold = 1'b0;
        extra = 70;
      end
      if (b == 5) checkOutput("t3_data_tx", tx, 0);
      waitBitCnt(4'(b + 1), 200, n);
      checkOutput($sformatf("t3_len_bit%0d", b), n + extra, (b == 3) ? 114 : 64);
    end
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("t3_end_busy", busy, 0);
    checkOutput("t3_end_tx", tx, 1);
    enDiv = 1;
    repeat (8) tick();

    // 4) tx_start held high: 0x3C then 0xC3 back to back
    applyStimulus(1'b1, 8'h3C);
    tick();
    applyStimulus(1'b1, 8'hC3);
    checkFrame("t4a", 8'h3C);
    tick();
    checkOutput("t4_b2b_tx", tx, 0);
    checkOutput("t4_b2b_busy", busy, 1);
    applyStimulus(1'b0, 8'h00);
    checkFrame("t4b", 8'hC3);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || txDone !== 1'b0 || tx !== 1'b1) bad++;
    end
    checkOutput("t4_no_extra", bad, 0);

    // 5) reset asserted during data bit 4 of 0x0F
    applyStimulus(1'b1, 8'h0F);
    tick();
    applyStimulus(1'b0, 8'h00);
    waitBitCnt(4'd5, 100, n);
    checkOutput("t5_reach_bit4", n, 80);
    repeat (5) tick();
    checkOutput("t5_pre_tx", tx, 0);
    rst = 1'b0;
    #1;
    checkOutput("t5_async_tx", tx, 1);
    checkOutput("t5_async_busy", busy, 0);
    checkOutput("t5_async_bitcnt", bitCnt, 0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    checkOutput("t5_idle_tx", tx, 1);
    applyStimulus(1'b1, 8'h96);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("t5", 8'h96);
    repeat (5) tick();

`ifdef UART_TX_PARITY_EN
    // 6) parity frames: 0x07 -> parity 1, 0x03 -> parity 0
    applyStimulus(1'b1, 8'h07);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("t6_07", 8'h07);
    repeat (3) tick();
    applyStimulus(1'b1, 8'h03);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("t6_03", 8'h03);
    repeat (3) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
